reverb_tap_scheduler: RTL and testbench

- Sequences one shared delay-line RAM and one shared multiplier across three reverb taps, replacing three parallel RAM/multiplier paths.
- Accepts one audio sample per handshake, writes it into a circular buffer, then reads the three delayed taps one at a time.
- Scales each tap by its own gain, rounds and accumulates the result, and emits dry + wet output with a valid pulse.
- Sits between the LPF2 output and the output summing stage.

---
 rtl/reverb_tap_scheduler.sv | 171 +++++++++++++++++
 tb/tb_reverb_tap_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reverb_tap_scheduler.sv
// Three-tap reverb that time-shares one delay RAM and one multiplier; output = dry + sum of gated taps.
// Define REVERB_SAT_EN to clamp the output to the signed DATA_W range instead of wrapping.
module reverb_tap_scheduler #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int NTAPS  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] delay_1,
  input  logic [ADDR_W-1:0] delay_2,
  input  logic [ADDR_W-1:0] delay_3,
  input  logic [DATA_W-1:0] gain_1,
  input  logic [DATA_W-1:0] gain_2,
  input  logic [DATA_W-1:0] gain_3,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // state    | meaning
  // IDLE     | waiting for a sample
  // WR_RD0   | write sample, issue tap 1 read
  // RD1      | issue tap 2 read, accumulate tap 1
  // RD2      | issue tap 3 read, accumulate tap 2
  // ACC_LAST | accumulate tap 3, register result
  // EMIT     | present result, may accept the next sample
  typedef enum logic [2:0] {IDLE, WR_RD0, RD1, RD2, ACC_LAST, EMIT} state_t;

  localparam int ACC_W  = DATA_W + 2;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [ADDR_W-1:0]        wptr;
  logic [ADDR_W-1:0]        fill;
  logic [DATA_W-1:0]        sample_q;
  logic [ADDR_W-1:0]        dly_q  [NTAPS];
  logic [DATA_W-1:0]        gain_q [NTAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [DATA_W-1:0]        out_data_q;

  logic                     accept;
  logic                     acc_en;
  logic [ADDR_W-1:0]        cur_dly;
  logic [DATA_W-1:0]        cur_gain;
  logic                     cur_en;
  logic signed [PROD_W-1:0] rdata_x;
  logic signed [PROD_W-1:0] gain_x;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [DATA_W-1:0]        result;
  logic                     unused_bits;

  assign in_ready = !rst && (state == IDLE || state == EMIT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_raddr = '0;
    out_valid = 1'b0;
    acc_en    = 1'b0;
    cur_dly   = '0;
    cur_gain  = '0;
    case (state)
      IDLE:     if (accept) state_nxt = WR_RD0;
      WR_RD0: begin
        ram_we    = 1'b1;
        ram_raddr = wptr - dly_q[0];
        state_nxt = RD1;
      end
      RD1: begin
        ram_raddr = wptr - dly_q[1];
        acc_en    = 1'b1;
        cur_dly   = dly_q[0];
        cur_gain  = gain_q[0];
        state_nxt = RD2;
      end
      RD2: begin
        ram_raddr = wptr - dly_q[2];
        acc_en    = 1'b1;
        cur_dly   = dly_q[1];
        cur_gain  = gain_q[1];
        state_nxt = ACC_LAST;
      end
      ACC_LAST: begin
        acc_en    = 1'b1;
        cur_dly   = dly_q[2];
        cur_gain  = gain_q[2];
        state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        state_nxt = accept ? WR_RD0 : IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // A tap only counts once the buffer holds a sample that old, hiding stale RAM after reset.
  assign cur_en  = (cur_dly != '0) && (fill >= cur_dly);
  assign rdata_x = $signed({{DATA_W{ram_rdata[DATA_W-1]}}, ram_rdata});
  assign gain_x  = $signed({{DATA_W{cur_gain[DATA_W-1]}}, cur_gain});
  assign product = rdata_x * gain_x;
  // Arithmetic shift by DATA_W-1 plus the first dropped bit: round half up.
  assign term    = $signed({product[PROD_W-1], product[PROD_W-1:DATA_W-1]})
                 + $signed(ACC_W'(product[DATA_W-2]));
  assign acc_sum = acc + (cur_en ? term : '0);
  assign unused_bits = ^{product[DATA_W-3:0], acc_sum[ACC_W-1:DATA_W]};

  always_comb begin
    result = acc_sum[DATA_W-1:0];
`ifdef REVERB_SAT_EN
    if (acc_sum > ACC_MAX)      result = ACC_MAX[DATA_W-1:0];
    else if (acc_sum < ACC_MIN) result = ACC_MIN[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      fill       <= '0;
      sample_q   <= '0;
      acc        <= '0;
      out_data_q <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        dly_q[k]  <= '0;
        gain_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        sample_q  <= in_data;
        dly_q[0]  <= delay_1;
        dly_q[1]  <= delay_2;
        dly_q[2]  <= delay_3;
        gain_q[0] <= gain_1;
        gain_q[1] <= gain_2;
        gain_q[2] <= gain_3;
        acc       <= $signed({{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data});
      end else if (acc_en) begin
        acc <= acc_sum;
      end
      if (state == ACC_LAST) out_data_q <= result;
      if (state == EMIT) begin
        wptr <= wptr + 1'b1;
        if (fill != {ADDR_W{1'b1}}) fill <= fill + 1'b1;
      end
    end
  end

  assign ram_waddr = wptr;
  assign ram_wdata = sample_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_reverb_tap_scheduler.sv
// Scoreboard bench for reverb_tap_scheduler: directed samples push expected outputs, a monitor compares.
module tb_reverb_tap_scheduler;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
`ifdef REVERB_SAT_EN
  localparam logic [DATA_W-1:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [DATA_W-1:0] SAT_EXP = 16'hBFFD;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] delay_1 = '0, delay_2 = '0, delay_3 = '0;
  logic [DATA_W-1:0] gain_1 = '0, gain_2 = '0, gain_3 = '0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  reverb_tap_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NTAPS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .delay_1(delay_1), .delay_2(delay_2), .delay_3(delay_3),
    .gain_1(gain_1), .gain_2(gain_2), .gain_3(gain_3),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; unwritten locations return ram_default to stand in for stale contents.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ram_default = '0;
  logic [DATA_W-1:0] rd_tmp;
  always @(posedge clk) begin
    rd_tmp = mem.exists(ram_raddr) ? mem[ram_raddr] : ram_default;
    if (ram_we) mem[ram_waddr] = ram_wdata;
    ram_rdata <= rd_tmp;
  end

  int compared = 0;
  int mismatched = 0;
  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];
  int                acc_cyc_q[$];
  int                cyc = 0;
  int                we_cnt = 0;
  int                ov_count = 0;
  int                last_acc = 0;
  bit                have_last = 0;
  bit                hs_mode = 0;
  logic [ADDR_W-1:0] exp_wptr = '0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [DATA_W-1:0] cur_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor samples 1 unit after the falling edge, i.e. the values the next rising edge will see.
  initial begin
    logic [DATA_W-1:0] e;
    string t;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        acc_cyc_q.delete();
        we_cnt    = 0;
        exp_wptr  = '0;
        have_last = 0;
      end else begin
        if (ram_we) begin
          check("ram_waddr", 32'(ram_waddr), 32'(exp_wptr));
          check("ram_wdata", 32'(ram_wdata), 32'(cur_dat));
          we_cnt++;
          last_waddr = ram_waddr;
        end
        if (out_valid) begin
          ov_count++;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_out_valid: got out_data %h with no sample pending", out_data);
          end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(out_data), 32'(e));
          end
          if (acc_cyc_q.size() != 0) check("latency", cyc - acc_cyc_q.pop_front(), 5);
          check("ram_we_per_sample", we_cnt, 1);
          we_cnt   = 0;
          exp_wptr = exp_wptr + 1'b1;
        end
        if (in_valid && in_ready) begin
          acc_cyc_q.push_back(cyc);
          cur_dat = in_data;
          if (hs_mode && have_last) check("accept_interval", cyc - last_acc, 5);
          last_acc  = cyc;
          have_last = 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_taps(input logic [ADDR_W-1:0] d1, d2, d3, input logic [DATA_W-1:0] g1, g2, g3);
    delay_1 = d1; delay_2 = d2; delay_3 = d3;
    gain_1 = g1; gain_2 = g2; gain_3 = g3;
  endtask

  // Called on a falling edge; returns on the falling edge just after the accepting rising edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] e,
                      input string tag, input bit push, input bit hold);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    if (push) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout_%s: in_ready stayed %b, required 1", tag, in_ready);
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] imp_exp [6];
    int ov_before;
    imp_exp = '{16'h4000, 16'h0000, 16'h2000, 16'h2000, 16'h2000, 16'h0000};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_waddr", 32'(ram_waddr), 0);
    check("rst_ram_raddr", 32'(ram_raddr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 1);
    @(negedge clk);

    // impulse decay
    ram_default = 16'h5A5A;
    set_taps(2, 3, 4, 16'h4000, 16'h4000, 16'h4000);
    send(16'h4000, imp_exp[0], "impulse_0", 1, 0);
    for (int i = 1; i < 6; i++) send(16'h0000, imp_exp[i], $sformatf("impulse_%0d", i), 1, 0);
    wait_drain();

    // rounding
    do_reset();
    mem.delete();
    ram_default = '0;
    set_taps(1, 0, 0, 16'h0001, 16'h0000, 16'h0000);
    send(16'h4000, 16'h4000, "round_0", 1, 0);
    send(16'h0000, 16'h0001, "round_1", 1, 0);
    wait_drain();

    // fill gating over stale RAM
    do_reset();
    mem.delete();
    ram_default = 16'h1234;
    set_taps(5, 5, 5, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 7; i++)
      send(16'h0100, (i < 5) ? 16'h0100 : 16'h0400, $sformatf("fill_%0d", i), 1, 0);
    wait_drain();

    // handshake with in_valid held high
    do_reset();
    mem.delete();
    ram_default = '0;
    set_taps(0, 0, 0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    hs_mode = 1;
    for (int i = 0; i < 6; i++)
      send(16'(16'h0010 + i), 16'(16'h0010 + i), $sformatf("handshake_%0d", i), 1, 1);
    in_valid = 1'b0;
    wait_drain();
    hs_mode = 0;

    // saturation / wrap
    do_reset();
    mem.delete();
    set_taps(1, 1, 1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    send(16'h7000, 16'h7000, "sat_0", 1, 0);
    send(16'h7000, SAT_EXP, "sat_1", 1, 0);
    send(16'h7000, SAT_EXP, "sat_2", 1, 0);
    wait_drain();

    // config change two cycles after accept must not affect the in-flight sample
    do_reset();
    mem.delete();
    set_taps(1, 0, 0, 16'h4000, 16'h0000, 16'h0000);
    send(16'h2000, 16'h2000, "cfg_0", 1, 0);
    send(16'h0400, 16'h1400, "cfg_1", 1, 0);
    send(16'h0000, 16'h0200, "cfg_cur", 1, 0);
    @(negedge clk);
    delay_1 = 2;
    send(16'h0000, 16'h0200, "cfg_next", 1, 0);
    wait_drain();

    // reset three cycles after accept aborts the sample
    set_taps(0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    ov_before = ov_count;
    send(16'h1111, 16'h0000, "abort", 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_out_valid", ov_count, ov_before);
    send(16'h2222, 16'h2222, "after_abort", 1, 0);
    wait_drain();
    check("abort_next_waddr", 32'(last_waddr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
